// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with a hardware
// clear sequencer, optional hardwired zero register and optional write-to-read bypass.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset; restarts the clear sweep
//   clr_req  start a clear sweep (honoured only when idle)
//   busy     clear sweep in progress; ports are inert and reads return 0
//   we       per-write-port enable            [NW]
//   waddr    packed write addresses           [NW*AW], port i at [i*AW +: AW]
//   wdata    packed write data                [NW*XLEN], port i at [i*XLEN +: XLEN]
//   raddr    packed read addresses            [NR*AW]
//   rdata    packed read data, combinational  [NR*XLEN]
module regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned NR       = 2,
    parameter int unsigned NW       = 1,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 0,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    input  logic [NW-1:0]     we,
    input  logic [NW*AW-1:0]  waddr,
    input  logic [NW*XLEN-1:0] wdata,
    input  logic [NR*AW-1:0]  raddr,
    output logic [NR*XLEN-1:0] rdata
);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t          state;
    logic [AW-1:0]   ptr;
    logic [XLEN-1:0] regs [DEPTH];

    logic [AW-1:0]   waddr_a [NW];
    logic [XLEN-1:0] wdata_a [NW];
    logic [NW-1:0]   wen_eff;

    // Unpack write ports and drop writes aimed at the hardwired zero register.
    for (genvar i = 0; i < NW; i++) begin : g_wport
        assign waddr_a[i] = waddr[i*AW +: AW];
        assign wdata_a[i] = wdata[i*XLEN +: XLEN];
        assign wen_eff[i] = we[i] && !((ZERO_REG != 0) && (waddr_a[i] == '0));
    end

    // Sweep sequencer: busy is a registered copy of (state == CLEAR).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= CLEAR;
            ptr   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    ptr <= ptr + AW'(1);
                    if (ptr == AW'(DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                IDLE: begin
                    if (clr_req) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                default: begin
                    state <= CLEAR;
                    ptr   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Storage has no reset; the sweep borrows the write path while busy.
    // Ports are applied in ascending order so the highest enabled port wins.
    always_ff @(posedge clk) begin
        if (busy) begin
            regs[ptr] <= '0;
        end else begin
            for (int i = 0; i < NW; i++) begin
                if (wen_eff[i]) begin
                    regs[waddr_a[i]] <= wdata_a[i];
                end
            end
        end
    end

    // Read ports: array value, optional bypass, then zero-register and busy masks.
    for (genvar j = 0; j < NR; j++) begin : g_rport
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;

        assign ra = raddr[j*AW +: AW];

        always_comb begin
            rd = regs[ra];
            if (BYPASS != 0) begin
                for (int i = 0; i < NW; i++) begin
                    if (wen_eff[i] && (waddr_a[i] == ra)) begin
                        rd = wdata_a[i];
                    end
                end
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd = '0;
            end
            if (busy) begin
                rd = '0;
            end
        end

        assign rdata[j*XLEN +: XLEN] = rd;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp. Two instances (bypass on/off)
// share stimulus; a reference model predicts busy and read data per cycle.
module tb_regfile_mp;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned NR    = 2;
    localparam int unsigned NW    = 2;
    localparam int unsigned AW    = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              clr_req;
    logic [NW-1:0]     we;
    logic [NW*AW-1:0]  waddr;
    logic [NW*XLEN-1:0] wdata;
    logic [NR*AW-1:0]  raddr;
    logic              busy_b, busy_n;
    logic [NR*XLEN-1:0] rdata_b, rdata_n;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NR(NR), .NW(NW), .ZERO_REG(1), .BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_b), .we(we),
        .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata_b)
    );

    regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NR(NR), .NW(NW), .ZERO_REG(1), .BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_n), .we(we),
        .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata_n)
    );

    typedef struct {
        logic                       busy;
        logic [NR-1:0][XLEN-1:0]    rb;
        logic [NR-1:0][XLEN-1:0]    rn;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: register contents plus remaining sweep cycles.
    logic [XLEN-1:0] mem [DEPTH];
    int              sweep_left;
    int              n_checks = 0;
    int              n_fail   = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        logic [AW-1:0] ra;
        e.busy = rst || (sweep_left > 0);
        for (int j = 0; j < NR; j++) begin
            ra = raddr[j*AW +: AW];
            e.rn[j] = (ra == '0) ? '0 : mem[ra];
            e.rb[j] = e.rn[j];
            if (ra != '0) begin
                for (int i = 0; i < NW; i++) begin
                    if (we[i] && (waddr[i*AW +: AW] == ra)) e.rb[j] = wdata[i*XLEN +: XLEN];
                end
            end
            if (e.busy) begin
                e.rn[j] = '0;
                e.rb[j] = '0;
            end
        end
        return e;
    endfunction

    // Effect of the coming rising edge on the model.
    task automatic advance_model();
        logic [AW-1:0] wa;
        if (rst) begin
            sweep_left = DEPTH;
        end else if (sweep_left > 0) begin
            sweep_left--;
            if (sweep_left == 0) begin
                for (int k = 0; k < DEPTH; k++) mem[k] = '0;
            end
        end else begin
            for (int i = 0; i < NW; i++) begin
                wa = waddr[i*AW +: AW];
                if (we[i] && (wa != '0)) mem[wa] = wdata[i*XLEN +: XLEN];
            end
            if (clr_req) sweep_left = DEPTH;
        end
    endtask

    task automatic drive(input logic r, input logic c, input logic [1:0] w,
                         input int a0, input logic [XLEN-1:0] d0,
                         input int a1, input logic [XLEN-1:0] d1,
                         input int r0, input int r1);
        @(posedge clk);
        #1;
        rst     = r;
        clr_req = c;
        we      = w;
        waddr   = {AW'(a1), AW'(a0)};
        wdata   = {d1, d0};
        raddr   = {AW'(r1), AW'(r0)};
        exp_q.push_back(predict());
        advance_model();
    endtask

    task automatic rand_cycle(input logic r, input logic c);
        drive(r, c, 2'($urandom), int'($urandom_range(0, 31)), $urandom,
              int'($urandom_range(0, 31)), $urandom,
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a += 2) drive(1'b0, 1'b0, 2'b00, 0, '0, 0, '0, a, a + 1);
    endtask

    // Monitor: compare every cycle that has a pending expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("busy_bypass", {31'b0, busy_b}, {31'b0, e.busy});
            check("busy_nobypass", {31'b0, busy_n}, {31'b0, e.busy});
            for (int j = 0; j < NR; j++) begin
                check($sformatf("rdata_bypass[%0d]", j), rdata_b[j*XLEN +: XLEN], e.rb[j]);
                check($sformatf("rdata_nobypass[%0d]", j), rdata_n[j*XLEN +: XLEN], e.rn[j]);
            end
        end
    end

    initial begin
        int wa0, wa1;
        rst = 1'b1; clr_req = 1'b0; we = '0; waddr = '0; wdata = '0; raddr = '0;
        sweep_left = DEPTH;
        for (int k = 0; k < DEPTH; k++) mem[k] = '0;

        // Reset held 3 cycles, then a sweep with writes/clr_req thrown at it.
        repeat (3) rand_cycle(1'b1, 1'b0);
        repeat (DEPTH) rand_cycle(1'b0, 1'($urandom));
        read_all();

        // Basic write/read and zero register.
        drive(1'b0, 1'b0, 2'b01, 5, 32'hDEADBEEF, 6, 32'h0, 5, 0);
        drive(1'b0, 1'b0, 2'b00, 0, '0, 0, '0, 5, 5);
        drive(1'b0, 1'b0, 2'b01, 0, 32'h00001234, 0, '0, 0, 0);
        drive(1'b0, 1'b0, 2'b00, 0, '0, 0, '0, 0, 0);

        // Same-address conflict, then distinct addresses.
        drive(1'b0, 1'b0, 2'b11, 7, 32'hAAAA0000, 7, 32'h0000BBBB, 7, 7);
        drive(1'b0, 1'b0, 2'b00, 0, '0, 0, '0, 7, 7);
        drive(1'b0, 1'b0, 2'b11, 3, 32'h33333333, 4, 32'h44444444, 3, 4);
        drive(1'b0, 1'b0, 2'b00, 0, '0, 0, '0, 3, 4);

        // Same-cycle write/read of register 9.
        drive(1'b0, 1'b0, 2'b01, 9, 32'hCAFEF00D, 0, '0, 9, 9);
        drive(1'b0, 1'b0, 2'b00, 0, '0, 0, '0, 9, 9);

        // Fill 1..31 with their index, then clear request; clr_req during busy ignored.
        for (int a = 1; a < DEPTH; a += 2) begin
            if (a + 1 < DEPTH) drive(1'b0, 1'b0, 2'b11, a, XLEN'(a), a + 1, XLEN'(a + 1), a, a + 1);
            else               drive(1'b0, 1'b0, 2'b01, a, XLEN'(a), 0, '0, a, 0);
        end
        read_all();
        drive(1'b0, 1'b1, 2'b00, 0, '0, 0, '0, 1, 31);
        repeat (DEPTH) rand_cycle(1'b0, 1'($urandom));
        read_all();

        // Reset in the middle of a clear sweep.
        for (int a = 1; a < DEPTH; a++) drive(1'b0, 1'b0, 2'b01, a, ~XLEN'(a), 0, '0, a, 0);
        drive(1'b0, 1'b1, 2'b00, 0, '0, 0, '0, 0, 0);
        repeat (10) rand_cycle(1'b0, 1'b0);
        repeat (2) rand_cycle(1'b1, 1'b0);
        repeat (DEPTH) rand_cycle(1'b0, 1'($urandom));
        read_all();

        // Random traffic biased toward a few addresses to provoke conflicts/bypass.
        repeat (600) begin
            wa0 = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31));
            wa1 = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31));
            drive(1'($urandom_range(0, 149) == 0), 1'($urandom_range(0, 59) == 0), 2'($urandom),
                  wa0, $urandom, wa1, $urandom,
                  ($urandom_range(0, 1) == 0) ? wa0 : int'($urandom_range(0, 31)),
                  ($urandom_range(0, 1) == 0) ? wa1 : int'($urandom_range(0, 3)));
        end
        repeat (DEPTH + 2) drive(1'b0, 1'b0, 2'b00, 0, '0, 0, '0, 0, 0);
        read_all();

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
